// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing handshake blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } tx_state_t;

    // Width able to hold 0..timeout; a disabled timeout still gets a 1-bit counter.
    function automatic int timeout_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sync_bit_ar.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
module sync_bit_ar (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Sending end of a four-phase req/ack crossing out of the clk domain.
//   state       | meaning
//   IDLE        | no transfer in flight, word accepted when ack_s is low
//   WAIT_ACK_HI | req high, waiting for the far side to acknowledge
//   WAIT_ACK_LO | req dropped, waiting for ack to return low
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [SIZE-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            req,
    output logic [SIZE-1:0] data_out,
    input  logic            ack,
    output logic            done,
    output logic            err
);

    localparam int            CW     = timeout_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    tx_state_t     state, state_nxt;
    logic          ack_s;
    logic          accept;
    logic          in_wait;
    logic          state_chg;
    logic [1:0]    warm_cnt;
    logic          warm_done;
    logic [CW-1:0] to_cnt;
    logic [CW-1:0] to_cnt_inc;

    sync_bit_ar u_ack_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ack),
        .q      (ack_s)
    );

    // ack_s reads 0 straight out of reset even if the far side still holds ack;
    // hold off readiness until the synchronizer has refilled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            warm_cnt <= 2'd2;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt - 2'd1;
        end
    end

    assign warm_done = (warm_cnt == 2'd0);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = WAIT_ACK_HI;
            end
            WAIT_ACK_HI: begin
                if (ack_s) state_nxt = WAIT_ACK_LO;
            end
            WAIT_ACK_LO: begin
                if (accept)      state_nxt = WAIT_ACK_HI;
                else if (!ack_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The completion cycle of WAIT_ACK_LO already accepts the next word,
    // which gives the 6-cycle minimum period.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = warm_done && !ack_s;
            end
            WAIT_ACK_LO: begin
                in_ready = !ack_s;
                done     = !ack_s;
            end
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req      <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            req      <= 1'b1;
            data_out <= in_data;
        end else if (state == WAIT_ACK_HI && ack_s) begin
            req      <= 1'b0;
        end
    end

    assign in_wait    = (state != IDLE);
    assign state_chg  = (state_nxt != state);
    assign to_cnt_inc = to_cnt + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state_chg || !in_wait) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt_inc;
            end
            if (TIMEOUT != 0 && in_wait && !state_chg && to_cnt_inc == TO_MAX) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboarded bench for cdc_handshake_tx with a behavioural far-side receiver.
module tb_cdc_handshake_tx;

    localparam int SIZE = 8;
    localparam int TO   = 16;

    logic            clk      = 1'b0;
    logic            resetn   = 1'b0;
    logic [SIZE-1:0] in_data  = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            req;
    logic [SIZE-1:0] data_out;
    logic            ack      = 1'b0;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    cdc_handshake_tx #(.SIZE(SIZE), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .req      (req),
        .data_out (data_out),
        .ack      (ack),
        .done     (done),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int rx_cnt   = 0;
    int acc_cyc  = 0;
    logic [SIZE-1:0] exp_q[$];

    bit far_en   = 1'b0;
    bit far_rand = 1'b0;
    int far_dly  = 3;
    bit scramble = 1'b0;
    bit stab_en  = 1'b0;

    logic [1:0] ack_sh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference view of the synchronized acknowledge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) ack_sh <= 2'b00;
        else         ack_sh <= {ack_sh[0], ack};
    end

    // Monitor: far-side capture against the scoreboard, done counting, data stability.
    initial begin
        logic            req_q = 1'b0;
        logic            acc_q = 1'b0;
        logic            ack_s_prev = 1'b0;
        logic [SIZE-1:0] dat_q = '0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (req && !req_q) begin
                check("req_rise_with_ack_s_low", 32'(ack_s_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none", data_out);
                end else begin
                    check("rx_word", 32'(data_out), 32'(exp_q.pop_front()));
                end
                rx_cnt++;
            end
            if (stab_en && data_out !== dat_q) begin
                check("data_change_on_accept", 32'(acc_q), 32'd1);
            end
            req_q      = req;
            dat_q      = data_out;
            acc_q      = in_valid && in_ready;
            ack_s_prev = ack_sh[1];
        end
    end

    // Far side: echo req onto ack after a fixed or random number of cycles.
    initial begin
        bit pend = 1'b0;
        int left = 0;
        forever begin
            @(negedge clk);
            if (!far_en || ack == req) begin
                pend = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    left = far_rand ? int'($urandom_range(1, 20)) : far_dly;
                end
                if (left == 0) begin
                    ack  = req;
                    pend = 1'b0;
                end else begin
                    left--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (scramble && !in_valid) in_data = SIZE'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [SIZE-1:0] w, input int limit);
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(w);
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", w);
        end
    endtask

    initial begin
        int base;
        int rx0;
        int c1, c2, c3;
        int e0;
        bit seen;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_req",      32'(req),      32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // single word, echo after 3 cycles
        far_en = 1'b1; far_dly = 3;
        base = done_cnt; rx0 = rx_cnt;
        @(posedge clk); #1;
        send(8'hA5, 20);
        in_valid = 1'b0;
        check("t1_req_high", 32'(req),      32'd1);
        check("t1_data",     32'(data_out), 32'hA5);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("t1_done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_done_once", 32'(done_cnt - base), 32'd1);
        check("t1_rx_once",   32'(rx_cnt - rx0),    32'd1);
        check("t1_ready",     32'(in_ready),        32'd1);
        check("t1_data_hold", 32'(data_out),        32'hA5);

        // back-to-back with an ideal far side
        far_dly = 0; stab_en = 1'b1;
        base = done_cnt; rx0 = rx_cnt;
        @(posedge clk); #1;
        send(8'h01, 20); c1 = acc_cyc;
        send(8'h02, 20); c2 = acc_cyc;
        send(8'h03, 20); c3 = acc_cyc;
        in_valid = 1'b0;
        check("t2_period_1_2", 32'(c2 - c1), 32'd6);
        check("t2_period_2_3", 32'(c3 - c2), 32'd6);
        repeat (15) @(negedge clk);
        check("t2_done_count", 32'(done_cnt - base), 32'd3);
        check("t2_rx_count",   32'(rx_cnt - rx0),    32'd3);
        check("t2_last_data",  32'(data_out),        32'h03);
        stab_en = 1'b0;

        // timeout with ack tied low, then manual completion
        far_en = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        base = done_cnt;
        @(posedge clk); #1;
        send(8'h3C, 20);
        in_valid = 1'b0;
        e0 = acc_cyc;
        check("t3_err_early", 32'(err), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (err) seen = 1'b1;
        end
        check("t3_err_latency", 32'(cyc - e0), 32'd16);
        check("t3_req_held",    32'(req),      32'd1);
        check("t3_data_held",   32'(data_out), 32'h3C);
        ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_req_before_fall", 32'(req), 32'd1);
        @(negedge clk);
        check("t3_req_fall",        32'(req), 32'd0);
        ack = 1'b0;
        @(negedge clk);
        check("t3_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t3_done_pulse", 32'(done),     32'd1);
        check("t3_ready_pulse",32'(in_ready), 32'd1);
        @(negedge clk);
        check("t3_done_clear", 32'(done),     32'd0);
        check("t3_err_sticky", 32'(err),      32'd1);
        check("t3_data_after", 32'(data_out), 32'h3C);
        check("t3_done_count", 32'(done_cnt - base), 32'd1);

        // reset in WAIT_ACK_LO while ack is still high
        @(posedge clk); #1;
        send(8'h5A, 20);
        in_valid = 1'b0;
        @(negedge clk);
        ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!req) seen = 1'b1;
        end
        check("t4_reached_lo", 32'(seen), 32'd1);
        resetn = 1'b0;
        #1;
        check("t4_rst_req",   32'(req),      32'd0);
        check("t4_rst_data",  32'(data_out), 32'd0);
        check("t4_rst_err",   32'(err),      32'd0);
        check("t4_rst_done",  32'(done),     32'd0);
        check("t4_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        resetn   = 1'b1;
        in_data  = 8'h77;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ready_blocked", 32'(in_ready), 32'd0);
            check("t4_no_accept",     32'(req),      32'd0);
        end
        ack      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_ready_one_edge",  32'(in_ready), 32'd0);
        @(negedge clk);
        check("t4_ready_two_edges", 32'(in_ready), 32'd1);
        check("t4_data_untouched",  32'(data_out), 32'd0);

        // random data and random far-side delays
        far_en = 1'b1; far_rand = 1'b1; scramble = 1'b1; stab_en = 1'b1;
        base = done_cnt; rx0 = rx_cnt;
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(SIZE'($urandom), 200);
            in_valid = 1'b0;
        end
        repeat (100) @(negedge clk);
        check("t5_done_count", 32'(done_cnt - base), 32'd12);
        check("t5_rx_count",   32'(rx_cnt - rx0),    32'd12);
        check("t5_sb_empty",   32'(exp_q.size()),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
